// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and port-op encoding for sync_1p_wbuf_fifo
package sync_fifo_pkg;

   localparam int WBUF_DEPTH     = 4;
   localparam int OBUF_DEPTH     = 4;
   localparam int RAM_RD_LATENCY = 2;

   typedef enum logic [1:0] {
      PORT_IDLE,
      PORT_READ,
      PORT_BYPASS,
      PORT_WRITE
   } port_op_t;

endpackage

// File: rtl/reg_fifo.sv
// rtl/reg_fifo.sv - small register FIFO; callers never push when full
module reg_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [DATA_WIDTH-1:0]  push_data_i,
   input  logic                   pop_i,
   output logic [DATA_WIDTH-1:0]  head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         rptr_q;
   logic [AW-1:0]         wptr_q;
   logic [AW:0]           cnt_q;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH));
   assign do_pop  = pop_i && (cnt_q != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/single_port_RAM.sv
// rtl/single_port_RAM.sv - single-port RAM, read data two cycles after the address
module single_port_RAM #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_stage_q;
   logic [DATA_WIDTH-1:0] rd_q;

   // Array read is registered, then re-registered on the output side.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) mem_q[addr_i] <= wdata_i;
         else      rd_stage_q    <= mem_q[addr_i];
      end
      rd_q <= rd_stage_q;
   end

   assign rdata_o = rd_q;

endmodule

// File: rtl/sync_1p_wbuf_fifo.sv
// rtl/sync_1p_wbuf_fifo.sv - single-port-RAM FIFO with write staging buffer,
// read-priority port arbitration and an empty-RAM bypass into the output buffer
module sync_1p_wbuf_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 256,
   parameter int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     clear,
   output logic [LB_FIFO_DEPTH:0]   count
);

   localparam int CW  = LB_FIFO_DEPTH + 1;
   localparam int WCW = $clog2(WBUF_DEPTH) + 1;
   localparam int OCW = $clog2(OBUF_DEPTH) + 1;

   logic                     flush;
   logic                     in_exec;
   logic                     out_exec;
   port_op_t                 port_op;

   logic [LB_FIFO_DEPTH-1:0] raddr_q, raddr_d;
   logic [LB_FIFO_DEPTH-1:0] waddr_q, waddr_d;
   logic [CW-1:0]            mem_cnt_q, mem_cnt_d;
   logic [CW-1:0]            count_q, count_d;
   logic [RAM_RD_LATENCY-1:0] vld_q, vld_d;

   logic [WCW-1:0]           wbuf_cnt;
   logic [DATA_WIDTH-1:0]    wbuf_head;
   logic                     wbuf_empty;
   logic                     wbuf_full;
   logic                     wbuf_pop;

   logic [OCW-1:0]           obuf_cnt;
   logic                     obuf_push;
   logic [DATA_WIDTH-1:0]    obuf_push_data;

   logic [1:0]               inflight;
   logic [3:0]               obuf_occ;
   logic                     pipe_out;
   logic [DATA_WIDTH-1:0]    ram_rdata;

   assign flush      = rst | clear;
   assign wbuf_empty = (wbuf_cnt == '0);
   assign wbuf_full  = (wbuf_cnt == WCW'(WBUF_DEPTH));
   assign in_ready   = (count_q < CW'(FIFO_DEPTH)) && !wbuf_full;
   assign out_valid  = (obuf_cnt != '0);
   assign in_exec    = in_valid & in_ready;
   assign out_exec   = out_valid & out_ready;
   assign count      = count_q;

   assign pipe_out = vld_q[RAM_RD_LATENCY-1];
   assign inflight = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
   assign obuf_occ = 4'(obuf_cnt) + 4'(inflight);

   // Reads win the port; bypass only when nothing older sits in RAM or the pipe.
   always_comb begin
      port_op = PORT_IDLE;
      if (mem_cnt_q != '0 && obuf_occ < 4'(OBUF_DEPTH))
         port_op = PORT_READ;
      else if (mem_cnt_q == '0 && inflight == '0 && !wbuf_empty && obuf_cnt < OCW'(OBUF_DEPTH))
         port_op = PORT_BYPASS;
      else if (!wbuf_empty && mem_cnt_q < CW'(FIFO_DEPTH))
         port_op = PORT_WRITE;
   end

   always_comb begin
      raddr_d   = raddr_q;
      waddr_d   = waddr_q;
      mem_cnt_d = mem_cnt_q;
      count_d   = count_q;
      vld_d     = {vld_q[RAM_RD_LATENCY-2:0], port_op == PORT_READ};
      if (port_op == PORT_READ) begin
         raddr_d   = raddr_q + LB_FIFO_DEPTH'(1);
         mem_cnt_d = mem_cnt_q - CW'(1);
      end else if (port_op == PORT_WRITE) begin
         waddr_d   = waddr_q + LB_FIFO_DEPTH'(1);
         mem_cnt_d = mem_cnt_q + CW'(1);
      end
      if (in_exec && !out_exec)      count_d = count_q + CW'(1);
      else if (!in_exec && out_exec) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         raddr_q   <= '0;
         waddr_q   <= '0;
         mem_cnt_q <= '0;
         count_q   <= '0;
         vld_q     <= '0;
      end else begin
         raddr_q   <= raddr_d;
         waddr_q   <= waddr_d;
         mem_cnt_q <= mem_cnt_d;
         count_q   <= count_d;
         vld_q     <= vld_d;
      end
   end

   assign wbuf_pop       = (port_op == PORT_BYPASS) || (port_op == PORT_WRITE);
   assign obuf_push      = pipe_out || (port_op == PORT_BYPASS);
   assign obuf_push_data = pipe_out ? ram_rdata : wbuf_head;

   reg_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk_i       (clk),
      .rst_i       (flush),
      .push_i      (in_exec),
      .push_data_i (in_data),
      .pop_i       (wbuf_pop),
      .head_o      (wbuf_head),
      .count_o     (wbuf_cnt)
   );

   single_port_RAM #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(LB_FIFO_DEPTH)) u_ram (
      .clk_i   (clk),
      .en_i    ((port_op == PORT_READ) || (port_op == PORT_WRITE)),
      .we_i    (port_op == PORT_WRITE),
      .addr_i  ((port_op == PORT_WRITE) ? waddr_q : raddr_q),
      .wdata_i (wbuf_head),
      .rdata_o (ram_rdata)
   );

   reg_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(OBUF_DEPTH)) u_obuf (
      .clk_i       (clk),
      .rst_i       (flush),
      .push_i      (obuf_push),
      .push_data_i (obuf_push_data),
      .pop_i       (out_exec),
      .head_o      (out_data),
      .count_o     (obuf_cnt)
   );

   always_ff @(posedge clk) begin
      if (!rst) assert (!(pipe_out && port_op == PORT_BYPASS));
   end

endmodule

// File: tb/tb_sync_1p_wbuf_fifo.sv
// tb/tb_sync_1p_wbuf_fifo.sv - randomized and directed bench with a queue reference model
module tb_sync_1p_wbuf_fifo;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst, clear, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] count;

   int            n_checks = 0;
   int            n_pass   = 0;
   int            n_out    = 0;
   bit            mon_en   = 0;
   bit            full_seen;
   logic [DW-1:0] model_q [$];

   always #5 clk = ~clk;

   sync_1p_wbuf_fifo #(
      .DATA_WIDTH    (DW),
      .FIFO_DEPTH    (DEPTH),
      .LB_FIFO_DEPTH ($clog2(DEPTH))
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .clear     (clear),
      .count     (count)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: the FIFO is an ordered queue of accepted words; flush empties it.
   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("count", count, model_q.size());
         if (model_q.size() == DEPTH) check_eq("full_in_ready", in_ready, 0);
         if (model_q.size() == 0) check_eq("empty_out_valid", out_valid, 0);
         if (rst || clear) begin
            model_q.delete();
         end else begin
            if (out_valid && out_ready && model_q.size() > 0) begin
               check_eq("out_data", out_data, model_q.pop_front());
               n_out++;
            end
            if (in_valid && in_ready) model_q.push_back(in_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      for (int k = 0; k < 200; k++) begin
         if (in_ready) begin
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
      end
      in_valid = 1'b0;
      check_eq("push_timeout", 0, 1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         if (model_q.size() == 0 && !out_valid) break;
         tick();
      end
      check_eq("drain_empty", model_q.size(), 0);
      tick();
      check_eq("drain_ovld", out_valid, 0);
   endtask

   task automatic single_latency(input logic [DW-1:0] d);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      check_eq("lat0_irdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check_eq("lat1_cnt", count, 1);
      check_eq("lat1_ovld", out_valid, 0);
      tick();
      check_eq("lat2_ovld", out_valid, 1);
      check_eq("lat2_data", out_data, d);
      tick();
      check_eq("lat3_cnt", count, 0);
   endtask

   task automatic fill(input int n, input int base);
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) push(DW'(base + i));
   endtask

   initial begin
      int nxt;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      tick(); tick();
      rst = 1'b0;
      mon_en = 1'b1;
      check_eq("rst_count", count, 0);
      check_eq("rst_ovld", out_valid, 0);
      check_eq("rst_irdy", in_ready, 1);

      single_latency(16'h00A5);

      fill(DEPTH, 0);
      check_eq("full_cnt", count, DEPTH);
      check_eq("full_irdy", in_ready, 0);
      out_ready = 1'b1;
      check_eq("full_pop_irdy_same", in_ready, 0);
      tick();
      check_eq("full_pop_irdy_next", in_ready, 1);
      drain();

      fill(DEPTH - 4, 0);
      out_ready = 1'b1;
      nxt = 100;
      for (int c = 0; c < 50; c++) begin
         in_valid = 1'b1;
         in_data  = DW'(nxt);
         if (c < 8) check_eq("stream_ovld", out_valid, 1);
         if (in_ready) nxt++;
         tick();
      end
      in_valid = 1'b0;
      drain();

      fill(10, 200);
      out_ready = 1'b1;
      tick(); tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_eq("clr_cnt", count, 0);
      check_eq("clr_ovld", out_valid, 0);
      single_latency(16'h003C);

      fill(DEPTH, 300);
      out_ready = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check_eq("rst_fly_ovld", out_valid, 0);
         check_eq("rst_fly_cnt", count, 0);
         tick();
      end
      single_latency(16'h0055);

      n_out = 0;
      full_seen = 1'b0;
      for (int c = 0; c < 60000 && n_out < 10000; c++) begin
         in_valid  = ($urandom_range(99) < 50);
         in_data   = DW'($urandom);
         out_ready = ($urandom_range(99) < 30);
         if (count == DEPTH) full_seen = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      check_eq("rand_done", n_out >= 10000, 1);
      check_eq("rand_full_seen", full_seen, 1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
